// File: rtl/wash_core.sv
// Washing-machine program sequencer: runs a small ROM program, one instruction per
// cycle, and drives at most one actuator at a time from a tick-driven countdown.
module wash_core #(
  parameter int INSTRS_WIDTH = 32,
  parameter int ADDR_WIDTH   = 8,
  parameter int START_ADDR   = 2,
  parameter int NUM_REGS     = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    abort,
  input  logic                    pause,
  input  logic                    tick,
  input  logic [INSTRS_WIDTH-1:0] instr,
  output logic [ADDR_WIDTH-1:0]   pc,
  output logic                    fill_valve,
  output logic                    drain_valve,
  output logic                    motor_fwd,
  output logic                    motor_rev,
  output logic                    busy,
  output logic                    done,
  output logic                    err
);
  localparam int RW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  localparam logic [7:0] OP_HALT = 8'h00;
  localparam logic [7:0] OP_WAIT = 8'h11;
  localparam logic [7:0] OP_FILL = 8'h12;
  localparam logic [7:0] OP_REL  = 8'h13;
  localparam logic [7:0] OP_FWD  = 8'h14;
  localparam logic [7:0] OP_REV  = 8'h15;
  localparam logic [7:0] OP_SET  = 8'h21;
  localparam logic [7:0] OP_DEC  = 8'h22;
  localparam logic [7:0] OP_J    = 8'h30;
  localparam logic [7:0] OP_JZ   = 8'h31;
  localparam logic [7:0] OP_JNZ  = 8'h32;

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, TIMED = 2'd2} state_t;

  state_t                state_reg, state_next;
  logic [ADDR_WIDTH-1:0] pc_reg, pc_next, pc_inc, jump_addr;
  logic [7:0]            op_reg, op_next, opc;
  logic [15:0]           timer_reg, timer_next, imm, rval, reg_wdata;
  logic [15:0]           regs_reg [NUM_REGS];
  logic [RW-1:0]         ridx;
  logic                  reg_we, done_reg, done_next, err_reg, err_next;
  logic [3:0]            act_reg, act_next;  // {rev, fwd, drain, fill}
  logic                  instr_unused;

  assign opc          = instr[7:0];
  assign ridx         = instr[8 +: RW];
  assign imm          = instr[31:16];
  assign rval         = regs_reg[ridx];
  assign pc_inc       = pc_reg + ADDR_WIDTH'(1);
  assign jump_addr    = imm[ADDR_WIDTH-1:0];
  assign instr_unused = ^instr;

  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    op_next    = op_reg;
    timer_next = timer_reg;
    reg_we     = 1'b0;
    reg_wdata  = rval;
    done_next  = 1'b0;
    err_next   = err_reg;
    act_next   = 4'b0000;
    case (state_reg)
      IDLE: begin
        if (start) begin
          pc_next    = ADDR_WIDTH'(START_ADDR);
          err_next   = 1'b0;
          state_next = EXEC;
        end
      end
      EXEC: begin
        case (opc)
          OP_HALT: begin
            state_next = IDLE;
            done_next  = 1'b1;
          end
          OP_WAIT, OP_FILL, OP_REL, OP_FWD, OP_REV: begin
            // A zero duration is a no-op: the actuator never sees a pulse.
            if (imm != 16'd0) begin
              op_next    = opc;
              timer_next = imm;
              state_next = TIMED;
            end else begin
              pc_next = pc_inc;
            end
          end
          OP_SET: begin
            reg_we    = 1'b1;
            reg_wdata = imm;
            pc_next   = pc_inc;
          end
          OP_DEC: begin
            reg_we    = 1'b1;
            reg_wdata = (rval == 16'd0) ? 16'd0 : rval - 16'd1;
            pc_next   = pc_inc;
          end
          OP_J:    pc_next = jump_addr;
          OP_JZ:   pc_next = (rval == 16'd0) ? jump_addr : pc_inc;
          OP_JNZ:  pc_next = (rval != 16'd0) ? jump_addr : pc_inc;
          default: begin
            err_next   = 1'b1;
            done_next  = 1'b1;
            state_next = IDLE;
          end
        endcase
      end
      TIMED: begin
        if (tick && !pause) begin
          timer_next = timer_reg - 16'd1;
          if (timer_reg == 16'd1) begin
            pc_next    = pc_inc;
            state_next = EXEC;
          end
        end
      end
      default: state_next = IDLE;
    endcase

    // Abort cancels every other update this cycle; only the state changes.
    if (abort) begin
      state_next = IDLE;
      pc_next    = pc_reg;
      op_next    = op_reg;
      timer_next = timer_reg;
      reg_we     = 1'b0;
      done_next  = 1'b0;
      err_next   = err_reg;
    end

    if (state_next == TIMED && !pause) begin
      case (op_next)
        OP_FILL: act_next = 4'b0001;
        OP_REL:  act_next = 4'b0010;
        OP_FWD:  act_next = 4'b0100;
        OP_REV:  act_next = 4'b1000;
        default: act_next = 4'b0000;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      pc_reg    <= '0;
      op_reg    <= OP_HALT;
      timer_reg <= '0;
      done_reg  <= 1'b0;
      err_reg   <= 1'b0;
      act_reg   <= 4'b0000;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      op_reg    <= op_next;
      timer_reg <= timer_next;
      done_reg  <= done_next;
      err_reg   <= err_next;
      act_reg   <= act_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs_reg[i] <= '0;
    end else if (reg_we) begin
      regs_reg[ridx] <= reg_wdata;
    end
  end

  assign pc          = pc_reg;
  assign fill_valve  = act_reg[0];
  assign drain_valve = act_reg[1];
  assign motor_fwd   = act_reg[2];
  assign motor_rev   = act_reg[3];
  assign busy        = (state_reg != IDLE);
  assign done        = done_reg;
  assign err         = err_reg;
endmodule

// File: tb/tb_wash_core.sv
// Bench for wash_core: directed program scenarios plus random programs and inputs,
// all checked cycle by cycle against an instruction-level reference model.
`timescale 1ns/1ps
module tb_wash_core;
  localparam int START = 2;

  logic        clk = 1'b0;
  logic        rst_n, start, abort, pause, tick;
  logic [31:0] instr;
  logic [7:0]  pc;
  logic        fill_valve, drain_valve, motor_fwd, motor_rev, busy, done, err;
  logic [31:0] rom [256];

  int total = 0;
  int bad   = 0;

  wash_core #(.INSTRS_WIDTH(32), .ADDR_WIDTH(8), .START_ADDR(START), .NUM_REGS(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .pause(pause), .tick(tick),
    .instr(instr), .pc(pc), .fill_valve(fill_valve), .drain_valve(drain_valve),
    .motor_fwd(motor_fwd), .motor_rev(motor_rev), .busy(busy), .done(done), .err(err)
  );

  assign instr = rom[pc];
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got=running exp=finished");
    $fatal(1);
  end

  // Reference model: program interpreter stepped once per clock edge.
  int       m_mode;  // 0 idle, 1 executing, 2 timed step
  int       m_pc, m_timer, m_op;
  int       m_regs [4];
  bit       m_done, m_err;
  bit [3:0] m_act;   // {fill, drain, fwd, rev}

  task automatic model_update();
    logic [31:0] w;
    int op, r, imm;
    if (!rst_n) begin
      m_mode = 0; m_pc = 0; m_timer = 0; m_op = 0;
      foreach (m_regs[i]) m_regs[i] = 0;
      m_done = 0; m_err = 0; m_act = 4'b0000;
      return;
    end
    if (abort) begin
      m_mode = 0; m_done = 0; m_act = 4'b0000;
      return;
    end
    m_done = 0;
    case (m_mode)
      0: if (start) begin m_pc = START; m_err = 0; m_mode = 1; end
      1: begin
        w = rom[m_pc];
        op = int'(w[7:0]); r = int'(w[9:8]); imm = int'(w[31:16]);
        case (op)
          'h00: begin m_mode = 0; m_done = 1; end
          'h11, 'h12, 'h13, 'h14, 'h15:
            if (imm > 0) begin m_op = op; m_timer = imm; m_mode = 2; end
            else m_pc = (m_pc + 1) % 256;
          'h21: begin m_regs[r] = imm; m_pc = (m_pc + 1) % 256; end
          'h22: begin if (m_regs[r] > 0) m_regs[r]--; m_pc = (m_pc + 1) % 256; end
          'h30: m_pc = imm % 256;
          'h31: m_pc = (m_regs[r] == 0) ? imm % 256 : (m_pc + 1) % 256;
          'h32: m_pc = (m_regs[r] != 0) ? imm % 256 : (m_pc + 1) % 256;
          default: begin m_err = 1; m_done = 1; m_mode = 0; end
        endcase
      end
      default: if (tick && !pause) begin
        m_timer--;
        if (m_timer == 0) begin m_pc = (m_pc + 1) % 256; m_mode = 1; end
      end
    endcase
    m_act = 4'b0000;
    if (m_mode == 2 && !pause) begin
      if (m_op == 'h12) m_act = 4'b1000;
      if (m_op == 'h13) m_act = 4'b0100;
      if (m_op == 'h14) m_act = 4'b0010;
      if (m_op == 'h15) m_act = 4'b0001;
    end
  endtask

  function automatic logic [14:0] exp_vec();
    logic [7:0] p;
    logic       b;
    p = m_pc[7:0];
    b = (m_mode != 0);
    return {p, m_act, b, m_done, m_err};
  endfunction

  function automatic logic [14:0] dut_vec();
    return {pc, fill_valve, drain_valve, motor_fwd, motor_rev, busy, done, err};
  endfunction

  function automatic logic [31:0] mk(input logic [7:0] op, input logic [7:0] r, input logic [15:0] imm);
    return {imm, r, op};
  endfunction

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = mk(8'h7F, 8'h00, 16'h0000);
  endtask

  task automatic idle_inputs();
    rst_n = 1'b1; start = 1'b0; abort = 1'b0; pause = 1'b0; tick = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b1; abort = 1'b1; pause = 1'b1; tick = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      total++;
      if (dut_vec() !== 15'd0) begin
        bad++; $display("FAIL reset_state cyc=%0d got=%h exp=%h", c, dut_vec(), 15'd0);
      end
    end
    idle_inputs();
    step();
    total++;
    if (dut_vec() !== exp_vec()) begin
      bad++; $display("FAIL reset_release got=%h exp=%h", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_wash_program();
    int n_fill, n_drain, n_fwd, n_rev, done_pc;
    bit fin;
    n_fill = 0; n_drain = 0; n_fwd = 0; n_rev = 0; done_pc = -1; fin = 0;
    clear_rom();
    rom[2]  = mk(8'h21, 8'd0, 16'd4);
    rom[3]  = mk(8'h12, 8'd0, 16'd100);
    rom[4]  = mk(8'h22, 8'd0, 16'd0);
    rom[5]  = mk(8'h32, 8'd0, 16'd3);
    rom[6]  = mk(8'h13, 8'd0, 16'd400);
    rom[7]  = mk(8'h21, 8'd1, 16'd3);
    rom[8]  = mk(8'h14, 8'd0, 16'd200);
    rom[9]  = mk(8'h11, 8'd0, 16'd5);
    rom[10] = mk(8'h15, 8'd0, 16'd100);
    rom[11] = mk(8'h11, 8'd0, 16'd5);
    rom[12] = mk(8'h22, 8'd1, 16'd0);
    rom[13] = mk(8'h32, 8'd1, 16'd8);
    rom[14] = mk(8'h15, 8'd0, 16'd100);
    rom[15] = mk(8'h13, 8'd0, 16'd0);
    rom[16] = mk(8'h30, 8'd0, 16'd24);
    rom[24] = mk(8'h11, 8'd0, 16'd1);
    rom[25] = mk(8'h00, 8'd0, 16'd0);
    idle_inputs(); start = 1'b1;
    step();
    start = 1'b0; tick = 1'b1;
    for (int c = 0; c < 5000 && !fin; c++) begin
      step();
      total++;
      if (dut_vec() !== exp_vec()) begin
        bad++; $display("FAIL wash_cycle cyc=%0d got=%h exp=%h", c, dut_vec(), exp_vec());
      end
      if (fill_valve)  n_fill++;
      if (drain_valve) n_drain++;
      if (motor_fwd)   n_fwd++;
      if (motor_rev)   n_rev++;
      if (done === 1'b1) begin fin = 1; done_pc = int'(pc); end
    end
    total++; if (!fin)          begin bad++; $display("FAIL wash_timeout got=no_done exp=done"); end
    total++; if (n_fill != 400)  begin bad++; $display("FAIL wash_fill got=%0d exp=400", n_fill); end
    total++; if (n_drain != 400) begin bad++; $display("FAIL wash_drain got=%0d exp=400", n_drain); end
    total++; if (n_fwd != 600)   begin bad++; $display("FAIL wash_fwd got=%0d exp=600", n_fwd); end
    total++; if (n_rev != 400)   begin bad++; $display("FAIL wash_rev got=%0d exp=400", n_rev); end
    total++; if (done_pc != 25)  begin bad++; $display("FAIL wash_done_pc got=%0d exp=25", done_pc); end
    total++; if (err !== 1'b0)   begin bad++; $display("FAIL wash_err got=%b exp=0", err); end
    tick = 1'b0;
    step();
    total++; if (done !== 1'b0) begin bad++; $display("FAIL wash_done_width got=%b exp=0", done); end
  endtask

  task automatic test_pause();
    int fill_cnt, dones, left;
    bit trig, prev_pause;
    fill_cnt = 0; dones = 0; left = 0; trig = 0;
    clear_rom();
    rom[2] = mk(8'h12, 8'd0, 16'd5);
    rom[3] = mk(8'h00, 8'd0, 16'd0);
    idle_inputs(); start = 1'b1;
    step();
    start = 1'b0; tick = 1'b1;
    for (int c = 0; c < 60; c++) begin
      prev_pause = pause;
      step();
      total++;
      if (dut_vec() !== exp_vec()) begin
        bad++; $display("FAIL pause_cycle cyc=%0d got=%h exp=%h", c, dut_vec(), exp_vec());
      end
      if (prev_pause) begin
        total++;
        if (fill_valve !== 1'b0) begin
          bad++; $display("FAIL pause_fill_drop cyc=%0d got=%b exp=0", c, fill_valve);
        end
      end
      if (fill_valve) fill_cnt++;
      if (done) dones++;
      if (left > 0) begin
        left--;
        if (left == 0) pause = 1'b0;
      end else if (!trig && fill_cnt == 2) begin
        trig = 1; pause = 1'b1; left = 10;
      end
    end
    total++; if (fill_cnt != 5) begin bad++; $display("FAIL pause_fill_ticks got=%0d exp=5", fill_cnt); end
    total++; if (dones != 1)    begin bad++; $display("FAIL pause_done_count got=%0d exp=1", dones); end
    tick = 1'b0;
  endtask

  task automatic test_abort();
    int rev_cnt, dones;
    rev_cnt = 0; dones = 0;
    clear_rom();
    rom[2] = mk(8'h15, 8'd0, 16'd50);
    idle_inputs(); start = 1'b1;
    step();
    start = 1'b0; tick = 1'b1;
    for (int c = 0; c < 40 && rev_cnt < 10; c++) begin
      step();
      total++;
      if (dut_vec() !== exp_vec()) begin
        bad++; $display("FAIL abort_run cyc=%0d got=%h exp=%h", c, dut_vec(), exp_vec());
      end
      if (motor_rev) rev_cnt++;
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    total++;
    if ({motor_rev, busy, done} !== 3'b000) begin
      bad++; $display("FAIL abort_next got=%b exp=000", {motor_rev, busy, done});
    end
    for (int c = 0; c < 20; c++) begin
      step();
      if (done) dones++;
    end
    total++; if (dones != 0) begin bad++; $display("FAIL abort_no_done got=%0d exp=0", dones); end
    start = 1'b1;
    step();
    start = 1'b0;
    total++;
    if ({pc, busy} !== {8'd2, 1'b1}) begin
      bad++; $display("FAIL abort_restart got=%h exp=%h", {pc, busy}, {8'd2, 1'b1});
    end
    abort = 1'b1; tick = 1'b0;
    step();
    abort = 1'b0;
  endtask

  task automatic test_loop();
    bit saw8, saw_done;
    saw8 = 0; saw_done = 0;
    clear_rom();
    rom[2] = mk(8'h21, 8'd1, 16'd1);
    rom[3] = mk(8'h22, 8'd1, 16'd0);
    rom[4] = mk(8'h22, 8'd1, 16'd0);
    rom[5] = mk(8'h31, 8'd1, 16'd8);
    rom[8] = mk(8'h00, 8'd0, 16'd0);
    idle_inputs(); start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 0; c < 20 && !saw_done; c++) begin
      if (pc === 8'd8) saw8 = 1;
      step();
      total++;
      if (dut_vec() !== exp_vec()) begin
        bad++; $display("FAIL loop_cycle cyc=%0d got=%h exp=%h", c, dut_vec(), exp_vec());
      end
      if (done) saw_done = 1;
    end
    total++; if (!saw8)        begin bad++; $display("FAIL loop_pc8 got=%0d exp=1", saw8); end
    total++; if (!saw_done)    begin bad++; $display("FAIL loop_done got=%0d exp=1", saw_done); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL loop_err got=%b exp=0", err); end
  endtask

  task automatic test_wrap();
    clear_rom();
    rom[2]   = mk(8'h30, 8'd0, 16'd255);
    rom[255] = mk(8'h21, 8'd0, 16'd7);
    rom[0]   = mk(8'h00, 8'd0, 16'd0);
    idle_inputs(); start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 0; c < 3; c++) step();
    total++;
    if ({pc, done, err} !== {8'd0, 1'b1, 1'b0}) begin
      bad++; $display("FAIL pc_wrap got=%h exp=%h", {pc, done, err}, {8'd0, 1'b1, 1'b0});
    end
  endtask

  task automatic test_illegal();
    clear_rom();
    rom[2] = mk(8'h7F, 8'd0, 16'd0);
    idle_inputs(); start = 1'b1;
    step();
    start = 1'b0;
    step();
    total++;
    if ({err, done, busy} !== 3'b110) begin
      bad++; $display("FAIL illegal_flag got=%b exp=110", {err, done, busy});
    end
    step();
    total++;
    if ({err, done} !== 2'b10) begin
      bad++; $display("FAIL illegal_sticky got=%b exp=10", {err, done});
    end
    start = 1'b1;
    step();
    start = 1'b0;
    total++;
    if ({err, busy} !== 2'b01) begin
      bad++; $display("FAIL illegal_clear got=%b exp=01", {err, busy});
    end
    step();
  endtask

  task automatic test_zero_imm_reset();
    int fwd_cnt;
    bit saw_done;
    fwd_cnt = 0; saw_done = 0;
    clear_rom();
    rom[2] = mk(8'h14, 8'd0, 16'd0);
    rom[3] = mk(8'h00, 8'd0, 16'd0);
    idle_inputs(); start = 1'b1;
    step();
    start = 1'b0; tick = 1'b1;
    for (int c = 0; c < 10; c++) begin
      step();
      if (motor_fwd) fwd_cnt++;
      if (done) saw_done = 1;
    end
    total++; if (fwd_cnt != 0) begin bad++; $display("FAIL zero_imm_fwd got=%0d exp=0", fwd_cnt); end
    total++; if (!saw_done)    begin bad++; $display("FAIL zero_imm_done got=0 exp=1"); end
    rom[2] = mk(8'h14, 8'd0, 16'd50);
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 0; c < 5; c++) step();
    total++;
    if (motor_fwd !== 1'b1) begin bad++; $display("FAIL midrun_fwd got=%b exp=1", motor_fwd); end
    rst_n = 1'b0; start = 1'b1;
    step();
    total++;
    if (dut_vec() !== 15'd0) begin
      bad++; $display("FAIL midrun_reset got=%h exp=%h", dut_vec(), 15'd0);
    end
    idle_inputs();
    step();
  endtask

  task automatic test_random();
    logic [7:0] ops [13];
    logic [7:0] op;
    logic [15:0] imm;
    ops = '{8'h00, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h21, 8'h22, 8'h30, 8'h31, 8'h32, 8'h7F, 8'h23};
    for (int p = 0; p < 6; p++) begin
      for (int a = 0; a < 256; a++) begin
        op = ops[$urandom_range(0, 12)];
        if (op >= 8'h11 && op <= 8'h15) imm = 16'($urandom_range(0, 3));
        else if (op == 8'h21)           imm = 16'($urandom_range(0, 3));
        else                            imm = 16'($urandom_range(0, 255));
        rom[a] = mk(op, 8'($urandom_range(0, 255)), imm);
      end
      for (int c = 0; c < 600; c++) begin
        start = ($urandom_range(0, 3) == 0);
        abort = ($urandom_range(0, 31) == 0);
        pause = ($urandom_range(0, 5) == 0);
        tick  = ($urandom_range(0, 1) == 0);
        rst_n = ($urandom_range(0, 199) != 0);
        step();
        total++;
        if (dut_vec() !== exp_vec()) begin
          bad++; $display("FAIL random prog=%0d cyc=%0d got=%h exp=%h", p, c, dut_vec(), exp_vec());
        end
      end
    end
    idle_inputs();
    step();
  endtask

  initial begin
    clear_rom();
    idle_inputs();
    test_reset();
    test_wash_program();
    test_pause();
    test_abort();
    test_loop();
    test_wrap();
    test_illegal();
    test_zero_imm_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
